// File: rtl/coffee_machine_ctrl_if.sv
// Panel/driver bundle for the coffee machine controller.
// master = panel side (drives buttons/sensors), slave = controller side.
interface coffee_machine_ctrl_if #(
  parameter int CUP_W   = 3,
  parameter int COUNT_W = 8
);
  logic               W;
  logic               T;
  logic               B;
  logic [CUP_W-1:0]   cups;
  logic               S;
  logic               P;
  logic               clear;
  logic               H;
  logic               G;
  logic               Brew;
  logic               Wait;
  logic               Error;
  logic [1:0]         err_code;
  logic [CUP_W-1:0]   cups_left;
  logic [COUNT_W-1:0] served;

  modport master (
    output W, T, B, cups, S, P, clear,
    input  H, G, Brew, Wait, Error, err_code, cups_left, served
  );

  modport slave (
    input  W, T, B, cups, S, P, clear,
    output H, G, Brew, Wait, Error, err_code, cups_left, served
  );
endinterface

// File: rtl/coffee_machine_ctrl.sv
// Moore coffee machine controller: water check, heating with timeout,
// multi-cup timed brewing, latched error code and wrapping served-cup counter.
module coffee_machine_ctrl #(
  parameter int HEAT_TIMEOUT = 200,
  parameter int BREW_CYCLES  = 50,
  parameter int MAX_CUPS     = 4,
  parameter int COUNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  coffee_machine_ctrl_if.slave bus
);
  localparam int CUP_W   = $clog2(MAX_CUPS + 1);
  localparam int TMR_MAX = (HEAT_TIMEOUT > BREW_CYCLES) ? HEAT_TIMEOUT : BREW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] HEAT_LAST = TMR_W'(HEAT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BREW_LAST = TMR_W'(BREW_CYCLES - 1);
  localparam logic [CUP_W-1:0] CUPS_MAX  = CUP_W'(MAX_CUPS);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PRESS = 2'b01;
  localparam logic [1:0] ERR_HEAT  = 2'b10;
  localparam logic [1:0] ERR_DRY   = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_HEAT  = 3'd1,
    S_READY = 3'd2,
    S_BREW  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_next;
  logic [CUP_W-1:0]   r_cups_left;
  logic [CUP_W-1:0]   w_cups_left_next;
  logic [COUNT_W-1:0] r_served;
  logic [COUNT_W-1:0] w_served_next;
  logic [1:0]         r_err_code;
  logic [1:0]         w_err_next;

  logic w_cups_ok;
  logic w_h;
  logic w_g;
  logic w_brew;
  logic w_wait;
  logic w_error;

  assign w_cups_ok = (bus.cups != '0) && (bus.cups <= CUPS_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT;
      r_timer     <= '0;
      r_cups_left <= '0;
      r_served    <= '0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_cups_left <= w_cups_left_next;
      r_served    <= w_served_next;
      r_err_code  <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_timer_next     = r_timer;
    w_cups_left_next = r_cups_left;
    w_served_next    = r_served;
    w_err_next       = r_err_code;
    // Over-pressure pre-empts every other transition; the code it latches is held in ERROR.
    if (r_state != S_ERROR && bus.P) begin
      w_state_next     = S_ERROR;
      w_err_next       = ERR_PRESS;
      w_cups_left_next = '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (bus.W) begin
            w_state_next = S_HEAT;
            w_timer_next = '0;
          end
        end
        S_HEAT: begin
          w_timer_next = r_timer + 1'b1;
          if (!bus.W) begin
            w_state_next = S_WAIT;
          end else if (bus.T) begin
            w_state_next = S_READY;
          end else if (r_timer == HEAT_LAST) begin
            w_state_next = S_ERROR;
            w_err_next   = ERR_HEAT;
          end
        end
        S_READY: begin
          if (!bus.W) begin
            w_state_next = S_WAIT;
          end else if (!bus.T) begin
            w_state_next = S_HEAT;
            w_timer_next = '0;
          end else if (bus.B && w_cups_ok) begin
            w_state_next     = S_BREW;
            w_cups_left_next = bus.cups;
            w_timer_next     = '0;
          end
        end
        S_BREW: begin
          w_timer_next = r_timer + 1'b1;
          if (!bus.W) begin
            w_state_next     = S_ERROR;
            w_err_next       = ERR_DRY;
            w_cups_left_next = '0;
          end else if (bus.S) begin
            w_state_next     = S_READY;
            w_cups_left_next = '0;
          end else if (r_timer == BREW_LAST) begin
            // Next cup starts on the same edge so the pump never gaps between cups.
            w_served_next    = r_served + 1'b1;
            w_cups_left_next = r_cups_left - 1'b1;
            w_timer_next     = '0;
            if (r_cups_left == CUP_W'(1)) begin
              w_state_next = S_READY;
            end
          end
        end
        S_ERROR: begin
          if (bus.clear && !bus.P) begin
            w_state_next = S_WAIT;
            w_err_next   = ERR_NONE;
          end
        end
        default: begin
          w_state_next = S_WAIT;
        end
      endcase
    end
  end

  always_comb begin
    w_h     = 1'b0;
    w_g     = 1'b0;
    w_brew  = 1'b0;
    w_wait  = 1'b0;
    w_error = 1'b0;
    case (r_state)
      S_WAIT:  w_wait  = 1'b1;
      S_HEAT:  w_h     = 1'b1;
      S_READY: w_g     = 1'b1;
      S_BREW:  w_brew  = 1'b1;
      S_ERROR: w_error = 1'b1;
      default: w_wait  = 1'b0;
    endcase
  end

  assign bus.H         = w_h;
  assign bus.G         = w_g;
  assign bus.Brew      = w_brew;
  assign bus.Wait      = w_wait;
  assign bus.Error     = w_error;
  assign bus.err_code  = r_err_code;
  assign bus.cups_left = r_cups_left;
  assign bus.served    = r_served;
endmodule

// File: tb/tb_coffee_machine_ctrl.sv
// Scenario bench for coffee_machine_ctrl: expected output vectors are queued
// as stimulus is applied and compared when the controller responds.
module tb_coffee_machine_ctrl;
  localparam int HEAT_TIMEOUT = 200;
  localparam int BREW_CYCLES  = 50;
  localparam int MAX_CUPS     = 4;
  localparam int COUNT_W      = 2;
  localparam int CUP_W        = 3;

  // Flag order: H, G, Brew, Wait, Error
  localparam logic [4:0]  F_H    = 5'b10000;
  localparam logic [4:0]  F_G    = 5'b01000;
  localparam logic [4:0]  F_BREW = 5'b00100;
  localparam logic [4:0]  F_WAIT = 5'b00010;
  localparam logic [4:0]  F_ERR  = 5'b00001;
  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_NOCL = 12'hFE3;

  typedef struct {
    string       name;
    logic [11:0] v;
    logic [11:0] m;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   served_exp = 0;

  coffee_machine_ctrl_if #(.CUP_W(CUP_W), .COUNT_W(COUNT_W)) bus();

  coffee_machine_ctrl #(
    .HEAT_TIMEOUT(HEAT_TIMEOUT),
    .BREW_CYCLES (BREW_CYCLES),
    .MAX_CUPS    (MAX_CUPS),
    .COUNT_W     (COUNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [11:0] obs;
  assign obs = {bus.H, bus.G, bus.Brew, bus.Wait, bus.Error,
                bus.err_code, bus.cups_left, bus.served};

  function automatic logic [11:0] mk(input logic [4:0] f, input logic [1:0] ec,
                                     input int cl, input int sv);
    return {f, ec, 3'(cl), 2'(sv)};
  endfunction

  task automatic expect_out(input string n, input logic [11:0] v, input logic [11:0] m);
    sb.push_back('{name: n, v: v, m: m});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.W = 1'b1;
    tick();
    tick();
    expect_out("reset_hold", mk(F_WAIT, 2'b00, 0, 0), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    reset = 1'b1;
    tick();
    expect_out("reset_first_edge", mk(F_H, 2'b00, 0, 0), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.W = 1'b0;
    tick();
    expect_out("heat_w_low", mk(F_WAIT, 2'b00, 0, 0), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] reset: WAIT after reset, HEAT on first edge after release", $time);
  endtask

  task automatic test_normal_brew();
    exp_t e;
    bus.W = 1'b1; bus.T = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      expect_out("normal_heat", mk(F_H, 2'b00, 0, served_exp), M_ALL);
      e = sb.pop_front(); n_assert++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s[%0d]: got %h, required %h", e.name, k, obs & e.m, e.v & e.m); end
      if (k < 9) tick();
    end
    bus.T = 1'b1;
    tick();
    bus.B = 1'b1; bus.cups = 3'd3;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    for (int k = 0; k < 3 * BREW_CYCLES; k++) begin
      expect_out("normal_brew", mk(F_BREW, 2'b00, 3 - k / BREW_CYCLES, served_exp + k / BREW_CYCLES), M_ALL);
      e = sb.pop_front(); n_assert++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s[%0d]: got %h, required %h", e.name, k, obs & e.m, e.v & e.m); end
      tick();
    end
    served_exp += 3;
    expect_out("normal_done", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] normal brew: 3 cups requested", $time);
  endtask

  task automatic test_heat_timeout();
    exp_t e;
    bus.W = 1'b0;
    tick();
    bus.W = 1'b1; bus.T = 1'b0;
    tick();
    for (int k = 0; k < HEAT_TIMEOUT; k++) begin
      expect_out("timeout_heat", mk(F_H, 2'b00, 0, served_exp), M_ALL);
      e = sb.pop_front(); n_assert++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s[%0d]: got %h, required %h", e.name, k, obs & e.m, e.v & e.m); end
      tick();
    end
    expect_out("timeout_error", mk(F_ERR, 2'b10, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.P = 1'b1;
    tick();
    expect_out("timeout_code_held", mk(F_ERR, 2'b10, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.P = 1'b0; bus.W = 1'b0; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_out("timeout_clear", mk(F_WAIT, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] heat timeout: error 10 then clear", $time);
  endtask

  task automatic test_heat_boundary();
    exp_t e;
    bus.W = 1'b1; bus.T = 1'b0;
    tick();
    repeat (HEAT_TIMEOUT - 1) tick();
    expect_out("heat_last_cycle", mk(F_H, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.T = 1'b1;
    tick();
    expect_out("ready_beats_timeout", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] heat boundary: T in final cycle reaches READY", $time);
  endtask

  task automatic test_overpressure();
    exp_t e;
    bus.B = 1'b1; bus.cups = 3'd2;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    repeat (20) tick();
    bus.P = 1'b1;
    tick();
    bus.P = 1'b0;
    expect_out("press_error", mk(F_ERR, 2'b01, 0, served_exp), M_NOCL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.P = 1'b1; bus.clear = 1'b1;
    tick();
    expect_out("press_clear_blocked", mk(F_ERR, 2'b01, 0, served_exp), M_NOCL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.P = 1'b0;
    tick();
    bus.clear = 1'b0;
    expect_out("press_clear", mk(F_WAIT, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    tick();
    tick();
    expect_out("press_recover_ready", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] over-pressure: error 01, clear gated by P", $time);
  endtask

  task automatic test_abort_dry();
    exp_t e;
    bus.B = 1'b1; bus.cups = 3'd2;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    repeat (BREW_CYCLES - 1) tick();
    expect_out("abort_last_cycle", mk(F_BREW, 2'b00, 2, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.S = 1'b1;
    tick();
    bus.S = 1'b0;
    expect_out("abort_ready", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.B = 1'b1; bus.cups = 3'd1;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    repeat (19) tick();
    bus.W = 1'b0; bus.S = 1'b1;
    tick();
    bus.S = 1'b0;
    expect_out("dry_error", mk(F_ERR, 2'b11, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_out("dry_clear", mk(F_WAIT, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] abort and dry run: stop in last cycle, W=0 beats S", $time);
  endtask

  task automatic test_invalid();
    exp_t e;
    bus.W = 1'b1; bus.T = 1'b1;
    tick();
    tick();
    bus.B = 1'b1; bus.cups = 3'd0;
    tick();
    expect_out("invalid_zero", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.cups = 3'(MAX_CUPS + 1);
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    expect_out("invalid_over_max", mk(F_G, 2'b00, 0, served_exp), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] invalid requests ignored", $time);
  endtask

  task automatic test_wrap_async();
    exp_t e;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    served_exp = 0;
    tick();
    tick();
    bus.B = 1'b1; bus.cups = 3'(MAX_CUPS);
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    for (int k = 0; k < MAX_CUPS * BREW_CYCLES; k++) begin
      expect_out("wrap_brew", mk(F_BREW, 2'b00, MAX_CUPS - k / BREW_CYCLES, served_exp + k / BREW_CYCLES), M_ALL);
      e = sb.pop_front(); n_assert++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s[%0d]: got %h, required %h", e.name, k, obs & e.m, e.v & e.m); end
      tick();
    end
    served_exp += MAX_CUPS;
    bus.B = 1'b1; bus.cups = 3'd1;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    repeat (BREW_CYCLES) tick();
    served_exp += 1;
    expect_out("wrap_served", mk(F_G, 2'b00, 0, 1), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    bus.B = 1'b1; bus.cups = 3'd2;
    tick();
    bus.B = 1'b0; bus.cups = 3'd0;
    repeat (30) tick();
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", mk(F_WAIT, 2'b00, 0, 0), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    tick();
    reset = 1'b1;
    tick();
    expect_out("post_reset_heat", mk(F_H, 2'b00, 0, 0), M_ALL);
    e = sb.pop_front(); n_assert++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: got %h, required %h", e.name, obs & e.m, e.v & e.m); end
    $display("[%0t] counter wrap and asynchronous reset mid-brew", $time);
  endtask

  initial begin
    bus.W = 1'b0; bus.T = 1'b0; bus.B = 1'b0; bus.cups = '0;
    bus.S = 1'b0; bus.P = 1'b0; bus.clear = 1'b0;
    test_reset();
    test_normal_brew();
    test_heat_timeout();
    test_heat_boundary();
    test_overpressure();
    test_abort_dry();
    test_invalid();
    test_wrap_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/coffee_machine_ctrl.md
# coffee_machine_ctrl

Parametrised successor to the single-cup coffee machine FSM: a Moore controller that sequences water check, heating, ready and brewing. Adds a heat timeout, multi-cup brewing with a per-cup brew timer, a latched error code with explicit clear, and a wrapping served-cup counter. Sits between the panel inputs (buttons, sensors) and the heater, indicator and pump drivers.

## Interface
Parameters:
- HEAT_TIMEOUT, 200: maximum cycles spent in HEAT before a timeout error (≥2).
- BREW_CYCLES, 50: cycles of pump-on per cup (≥2).
- MAX_CUPS, 4: largest accepted cup request (≥1).
- COUNT_W, 8: width of served-cup counter.
- Derived: CUP_W = $clog2(MAX_CUPS+1); TMR_W = $clog2(max(HEAT_TIMEOUT, BREW_CYCLES)).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- W  in  1  water level sufficient.
- T  in  1  brew temperature reached.
- B  in  1  brew request, sampled in READY.
- cups  in  CUP_W  requested cup count, sampled with B.
- S  in  1  stop; aborts brewing.
- P  in  1  over-pressure fault.
- clear  in  1  error acknowledge.
- H  out  1  heater on.
- G  out  1  ready indicator.
- Brew  out  1  pump on.
- Wait  out  1  idle/waiting indicator.
- Error  out  1  error indicator.
- err_code  out  2  00 none, 01 over-pressure, 10 heat timeout, 11 ran dry.
- cups_left  out  CUP_W  cups remaining in current brew, including the one in progress.
- served  out  COUNT_W  total completed cups, wraps modulo 2^COUNT_W.

## Operation
- States: WAIT, HEAT, READY, BREW, ERROR. Outputs decode the state register only; there are no combinational paths from inputs to outputs.
- Output decode: WAIT → Wait=1. HEAT → H=1. READY → G=1. BREW → Brew=1. ERROR → Error=1. All other flags are 0 in each state.
- Reset (reset=0, asynchronous): state=WAIT, timer=0, cups_left=0, served=0, err_code=00. Outputs are therefore Wait=1 and all other flags 0.
- Priority, evaluated each edge: P=1 in any non-ERROR state → ERROR with err_code=01. This overrides every other transition.
- WAIT:
  - W=1 → HEAT, timer cleared.
  - Otherwise stay.
- HEAT (timer increments each cycle):
  - W=0 → WAIT.
  - Else T=1 → READY.
  - Else timer==HEAT_TIMEOUT-1 → ERROR, err_code=10.
- READY:
  - W=0 → WAIT.
  - Else T=0 → HEAT, timer cleared.
  - Else B=1 with 1≤cups≤MAX_CUPS → BREW, cups_left=cups, timer cleared.
  - B=1 with cups=0 or cups>MAX_CUPS is ignored; stay in READY.
- BREW (timer increments each cycle):
  - W=0 → ERROR, err_code=11, cups_left=0.
  - Else S=1 → READY, cups_left=0, served unchanged.
  - Else timer==BREW_CYCLES-1 → served+1 and cups_left-1. Then go to READY if cups_left was 1; otherwise stay in BREW with timer cleared.
- ERROR:
  - Hold until clear=1 and P=0, then → WAIT with err_code=00.
  - clear=1 while P=1 → stay in ERROR.
  - err_code is held for the whole time in ERROR and is not overwritten by later P.
- served increments only on cup completion. It is never cleared except by reset.

## Timing
- Outputs change one edge after the causing input is sampled: the input is seen at edge k, and the output is valid after edge k.
- If no exit condition occurs, HEAT lasts exactly HEAT_TIMEOUT cycles. If T=1 in the final cycle, READY wins over timeout.
- An uninterrupted n-cup brew holds Brew=1 for exactly n×BREW_CYCLES consecutive cycles, with no gap between cups.
- cups_left decrements on the completing edge of each cup.
- Simultaneous events in the final BREW cycle: S=1 beats completion, so that cup is not counted. W=0 beats both S and completion.
- Reset asserted mid-brew: Brew drops immediately (asynchronously), served is cleared, and no partial cup is counted.
- When reset is released, the first transition occurs on the next rising edge.

## Test plan
- Normal brew (HEAT_TIMEOUT=200, BREW_CYCLES=50): reset, W=1, T=1 after 10 cycles, B=1 with cups=3 → Brew high for 150 cycles, cups_left steps 3→2→1→0, served=3, G=1 afterwards.
- Heat timeout: W=1, T held 0 → H=1 for exactly 200 cycles, then Error=1 with err_code=10. Then clear=1 → Wait=1, err_code=00.
- Over-pressure: P pulsed for one cycle mid-brew → ERROR, err_code=01, Brew=0, served unchanged. clear=1 with P=1 keeps ERROR; clear=1 with P=0 → WAIT.
- Abort and dry run: S=1 at cycle 49 of the first cup → READY, served unchanged, cups_left=0. New brew, then W=0 in cycle 20 → ERROR, err_code=11.
- Invalid request: in READY, B=1 with cups=0, then B=1 with cups=MAX_CUPS+1 → remains READY and G stays 1.
- Counter wrap and async reset (COUNT_W=2): brew 5 cups → served=1. Assert reset asynchronously between clock edges mid-brew → outputs go to the reset values immediately.
